// File: rtl/serial_frame_tx.sv
// Parallel-in, serial-out frame transmitter: start bit, data MSB-first,
// optional even-parity bit, stop bit; each bit held for BIT_CYCLES clocks.
module serial_frame_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int BIT_CYCLES = 4,
    parameter bit PARITY_EN  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  data_out,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                state_q, state_n;
    logic [CW-1:0]         cyc_q, cyc_n;
    logic [BW-1:0]         bit_q, bit_n;
    logic [DATA_WIDTH-1:0] shift_q, shift_n;
    logic                  parity_q, parity_n;
    logic                  data_out_n, frame_done_n;
    logic                  cyc_last;

    assign cyc_last = (cyc_q == CYC_LAST);

    // Outputs are computed from the next state and registered alongside it,
    // so every port is a flop output.
    always_comb begin
        state_n  = state_q;
        cyc_n    = cyc_q;
        bit_n    = bit_q;
        shift_n  = shift_q;
        parity_n = parity_q;

        case (state_q)
            S_IDLE: begin
                if (tx_valid && tx_ready) begin
                    state_n  = S_START;
                    cyc_n    = '0;
                    shift_n  = tx_data;
                    parity_n = ^tx_data;
                end
            end
            S_START: begin
                if (cyc_last) begin
                    state_n = S_DATA;
                    cyc_n   = '0;
                    bit_n   = '0;
                end else begin
                    cyc_n = cyc_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cyc_last) begin
                    cyc_n   = '0;
                    shift_n = shift_q << 1;
                    if (bit_q == BIT_LAST) begin
                        state_n = PARITY_EN ? S_PARITY : S_STOP;
                    end else begin
                        bit_n = bit_q + 1'b1;
                    end
                end else begin
                    cyc_n = cyc_q + 1'b1;
                end
            end
            S_PARITY: begin
                if (cyc_last) begin
                    state_n = S_STOP;
                    cyc_n   = '0;
                end else begin
                    cyc_n = cyc_q + 1'b1;
                end
            end
            S_STOP: begin
                if (cyc_last) begin
                    state_n = S_IDLE;
                    cyc_n   = '0;
                end else begin
                    cyc_n = cyc_q + 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
                cyc_n   = '0;
            end
        endcase

        data_out_n   = 1'b1;
        frame_done_n = 1'b0;
        case (state_n)
            S_START:  data_out_n = 1'b0;
            S_DATA:   data_out_n = shift_n[DATA_WIDTH-1];
            S_PARITY: data_out_n = parity_n;
            S_STOP:   frame_done_n = (cyc_n == CYC_LAST);
            default:  data_out_n = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; the
    // combinational block above uses blocking ones with defaults first.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cyc_q      <= '0;
            bit_q      <= '0;
            data_out   <= 1'b1;
            tx_ready   <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_n;
            cyc_q      <= cyc_n;
            bit_q      <= bit_n;
            data_out   <= data_out_n;
            tx_ready   <= (state_n == S_IDLE);
            busy       <= (state_n != S_IDLE);
            frame_done <= frame_done_n;
        end
    end

    // NOTE: the word and parity registers are left unreset: they are always
    // loaded on acceptance before any state that reads them.
    always_ff @(posedge clk) begin
        shift_q  <= shift_n;
        parity_q <= parity_n;
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx: an 8-bit/4-cycle/parity instance and an
// 8-bit/1-cycle/no-parity instance, checked at negedge against hand-built frames.
module tb_serial_frame_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data, tx_data_b;
    logic       tx_valid, tx_valid_b;
    logic       tx_ready, data_out, busy, frame_done;
    logic       tx_ready_b, data_out_b, busy_b, frame_done_b;

    int n_checks = 0;
    int n_errors = 0;

    serial_frame_tx #(.DATA_WIDTH(8), .BIT_CYCLES(4), .PARITY_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .data_out(data_out), .busy(busy), .frame_done(frame_done)
    );

    serial_frame_tx #(.DATA_WIDTH(8), .BIT_CYCLES(1), .PARITY_EN(1'b0)) dut_b (
        .clk(clk), .reset(reset), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
        .tx_ready(tx_ready_b), .data_out(data_out_b), .busy(busy_b), .frame_done(frame_done_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] data;
        logic [10:0] bits;   // start, data MSB-first, parity, stop
    } vec_t;

    vec_t vecs[3];

    // Compared vectors are {data_out, tx_ready, busy, frame_done}.
    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got {dout,rdy,busy,done}=%b expected %b", name, act, exp);
        end
    endtask

    task automatic check_idle(input string name);
        @(negedge clk);
        check(name, {data_out, tx_ready, busy, frame_done}, 4'b1100);
    endtask

    task automatic start_word(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_valid = 1'b0;
    endtask

    // Checks the first ncyc clocks of a frame, starting at the next negedge.
    task automatic check_frame(input string name, input logic [10:0] bits, input int ncyc);
        int          bi;
        logic [3:0]  e;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            bi = k / 4;
            e  = {bits[10-bi], 1'b0, 1'b1, (k == 43)};
            check($sformatf("%s clk%0d", name, k + 1),
                  {data_out, tx_ready, busy, frame_done}, e);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [9:0] fast_bits;

        vecs[0] = '{"a5", 8'hA5, 11'b0_10100101_0_1};
        vecs[1] = '{"80", 8'h80, 11'b0_10000000_1_1};
        vecs[2] = '{"7e", 8'h7E, 11'b0_01111110_0_1};

        // Reset with tx_valid high: must be ignored
        reset      = 1'b1;
        tx_valid   = 1'b1;
        tx_data    = 8'hA5;
        tx_valid_b = 1'b0;
        tx_data_b  = 8'h00;
        check_idle("reset cyc1");
        check_idle("reset cyc2");
        reset    = 1'b0;
        tx_valid = 1'b0;
        for (int i = 0; i < 3; i++) check_idle($sformatf("post-reset idle%0d", i));
        check("b idle after reset", {data_out_b, tx_ready_b, busy_b, frame_done_b}, 4'b1100);

        // Table of single frames
        for (int i = 0; i < 3; i++) begin
            start_word(vecs[i].data);
            check_frame(vecs[i].name, vecs[i].bits, 44);
            check_idle({vecs[i].name, " clk45"});
        end

        // Back-to-back with tx_valid held; tx_data changed right after acceptance
        @(negedge clk);
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_data = 8'h01;
        check_frame("b2b ff", 11'b0_11111111_0_1, 44);
        check_idle("b2b gap");
        @(posedge clk);
        #1 tx_valid = 1'b0;
        check_frame("b2b 01", 11'b0_00000001_1_1, 44);
        check_idle("b2b end");

        // Reset during the 3rd data bit of 0x00
        start_word(8'h00);
        check_frame("rst 00", 11'b0_00000000_0_1, 14);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check_idle("rst recover");
        check_idle("rst stays idle");
        start_word(8'h3C);
        check_frame("after rst 3c", 11'b0_00111100_0_1, 44);
        check_idle("after rst clk45");

        // Input hold: tx_data/tx_valid activity mid-frame has no effect
        start_word(8'h5A);
        fork
            check_frame("hold 5a", 11'b0_01011010_0_1, 44);
            begin
                repeat (10) @(negedge clk);
                tx_data  = 8'hFF;
                tx_valid = 1'b1;
                @(negedge clk);
                tx_valid = 1'b0;
                tx_data  = 8'h00;
            end
        join
        for (int i = 0; i < 3; i++) check_idle($sformatf("hold no extra%0d", i));

        // Fast bits, no parity, 0x81
        fast_bits = 10'b0_10000001_1;
        @(negedge clk);
        tx_data_b  = 8'h81;
        tx_valid_b = 1'b1;
        @(posedge clk);
        #1 tx_valid_b = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("fast 81 clk%0d", k + 1),
                  {data_out_b, tx_ready_b, busy_b, frame_done_b},
                  {fast_bits[9-k], 1'b0, 1'b1, (k == 9)});
        end
        @(negedge clk);
        check("fast 81 idle", {data_out_b, tx_ready_b, busy_b, frame_done_b}, 4'b1100);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
